// File: rtl/full_adder.sv
// full_adder: registered 1-bit full adder with valid qualification and bit-serial carry chaining; optional FULL_ADDER_STATS_EN adds op/carry counters
module full_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        serial_en,
    input  logic        sof,
    output logic        Sum,
    output logic        Carry,
    output logic        out_valid
`ifdef FULL_ADDER_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [15:0] carry_count
`endif
);
    logic       cin;
    logic [1:0] res;
    // Carry doubles as the serial carry register: both load on every valid op and hold otherwise
    always_comb begin
        cin = (serial_en && !sof) ? Carry : c;
        res = 2'(a) + 2'(b) + 2'(cin);
    end
    // Result registers; reset clears the carry chain and wins over in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum       <= 1'b0;
            Carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) {Carry, Sum} <= res;
        end
    end
`ifdef FULL_ADDER_STATS_EN
    // Wrapping statistics, updated on the same edge as the result
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count    <= '0;
            carry_count <= '0;
        end else if (in_valid) begin
            op_count    <= op_count + 16'd1;
            carry_count <= carry_count + 16'(res[1]);
        end
    end
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized and directed scoreboard bench for full_adder
module tb_full_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, serial_en = 1'b0, sof = 1'b0;
    logic Sum, Carry, out_valid;
`ifdef FULL_ADDER_STATS_EN
    logic [15:0] op_count, carry_count;
    logic [15:0] m_ops = '0, m_car = '0;
`endif
    int errors = 0;
    int checks = 0;
    logic [1:0] q[$];
    logic model_carry = 1'b0;
    logic rs = 1'b1;
    logic [1:0] last = 2'b00;
    logic [1:0] got;

    full_adder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .serial_en(serial_en), .sof(sof), .Sum(Sum), .Carry(Carry), .out_valid(out_valid)
`ifdef FULL_ADDER_STATS_EN
        , .op_count(op_count), .carry_count(carry_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and record the arithmetic outcome the spec demands
    task automatic op(input logic r, input logic v, input logic ia, input logic ib, input logic ic,
                      input logic se, input logic sf);
        int total;
        logic cin;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; a = ia; b = ib; c = ic; serial_en = se; sof = sf;
        if (r) model_carry = 1'b0;
        else if (v) begin
            cin = (se && !sf) ? model_carry : ic;
            total = int'(ia) + int'(ib) + int'(cin);
            q.push_back({total >= 2, total % 2 == 1});
            model_carry = total >= 2;
        end
    endtask

    task automatic word(input logic [15:0] aw, input logic [15:0] bw, input int n);
        for (int k = 0; k < n; k++) op(0, 1, aw[k], bw[k], 0, 1, k == 0);
    endtask

    // Remember whether the edge just taken was a reset edge
    always @(posedge clk) rs <= rst;

    // Monitor: pop and compare on every presented output, otherwise expect held values
    always @(negedge clk) begin
        if (rs) begin
            chk("reset_out", {13'd0, Sum, Carry, out_valid}, 16'd0);
            last = 2'b00;
`ifdef FULL_ADDER_STATS_EN
            m_ops = '0; m_car = '0;
`endif
        end else if (out_valid === 1'b1) begin
            if (q.size() == 0) chk("unexpected_valid", 16'd1, 16'd0);
            else begin
                got = q.pop_front();
                chk("sum_carry", {14'd0, Carry, Sum}, {14'd0, got});
                last = got;
`ifdef FULL_ADDER_STATS_EN
                m_ops = m_ops + 16'd1;
                m_car = m_car + 16'(got[1]);
`endif
            end
        end else begin
            chk("hold", {14'd0, Carry, Sum}, {14'd0, last});
        end
`ifdef FULL_ADDER_STATS_EN
        chk("op_count", op_count, m_ops);
        chk("carry_count", carry_count, m_car);
`endif
    end

    initial begin
        logic [2:0] abc;
        op(1, 1, 1, 1, 1, 0, 0);
        op(1, 1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            op(0, 1, abc[2], abc[1], abc[0], 0, 0);
        end
        for (int i = 0; i < 3; i++) op(0, 0, 1'(i), 1'(i + 1), 1'(i), 1, 0);
`ifdef FULL_ADDER_STATS_EN
        op(0, 0, 0, 0, 0, 0, 0);
        chk("sweep_ops", op_count, 16'd8);
        chk("sweep_carries", carry_count, 16'd4);
`endif
        word(16'h0007, 16'h0001, 4);
        op(0, 0, 0, 0, 0, 0, 0);
        chk("serial_0111_carry", {15'd0, Carry}, 16'd0);
        word(16'h000F, 16'h0001, 4);
        op(0, 0, 0, 0, 0, 0, 0);
        chk("serial_1111_carry", {15'd0, Carry}, 16'd1);
        op(0, 1, 1, 1, 0, 0, 0);
        op(0, 1, 0, 0, 0, 1, 1);
        op(0, 1, 1, 1, 0, 0, 0);
        op(0, 1, 0, 0, 0, 1, 0);
        op(0, 1, 1, 1, 0, 1, 1);
        op(0, 0, 0, 0, 0, 1, 0);
        op(0, 1, 0, 1, 0, 1, 0);
        op(1, 1, 1, 1, 1, 1, 0);
        op(0, 1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 400; i++)
            op($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
`ifdef FULL_ADDER_STATS_EN
        op(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65536; i++) op(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        op(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_ops", op_count, 16'd0);
`endif
        op(0, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
